// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Parametrised inter-stage pipeline register. Moves a data bundle
//            and a control bundle between two stages under a valid/ready
//            handshake, with an optional skid entry (registered in_ready),
//            synchronous flush for bubble insertion and a saturating
//            stall-cycle counter.
// Ports    : clk        - clock, all state changes on the rising edge
//            reset      - synchronous, active-low reset
//            flush      - synchronous kill of every held entry
//            in_valid   - upstream offers a bundle
//            in_ready   - this block accepts this cycle
//            in_data    - upstream data bundle  [DATA_W]
//            in_ctrl    - upstream control bundle [CTRL_W]
//            out_valid  - out_data/out_ctrl carry a valid bundle
//            out_ready  - downstream consumes this cycle
//            out_data   - registered data bundle [DATA_W]
//            out_ctrl   - registered control bundle, zero when out_valid=0
//            stall_cnt  - saturating count of stalled cycles [CNT_W]
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit               c_HAS_SKID = (SKID != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    logic w_accept;
    logic w_main_free;

    // With a skid entry, in_ready only looks at local state so the
    // out_ready -> in_ready path is broken; without it the stage can refill
    // in the same cycle it drains.
    generate
        if (c_HAS_SKID) begin : g_skid_ready
            assign in_ready = !skid_valid_q;
        end else begin : g_comb_ready
            assign in_ready = !main_valid_q | out_ready;
        end
    endgenerate

    assign w_accept    = in_valid & in_ready;
    assign w_main_free = !main_valid_q | out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        stall_cnt_d  = stall_cnt_q;

        // Main entry refills when empty or drained; the older skid bundle
        // always goes ahead of the input to keep acceptance order.
        if (w_main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
            end else begin
                // Bubble: ctrl forced to no-op, data left as is.
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end

        // An accept while main is held parks the bundle in the skid entry.
        // in_ready already guarantees the skid is empty here.
        if (c_HAS_SKID && w_accept && main_valid_q && !out_ready) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end

        // Flush overrides the handshake; a same-cycle accept is lost.
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end

        if (main_valid_q && !out_ready && (stall_cnt_q != c_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. Three instances share
//            one stimulus stream: SKID=1/CNT_W=16, SKID=0/CNT_W=16 and
//            SKID=1/CNT_W=4. A per-instance FIFO model predicts outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [95:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;

    logic        v1, r1, v0, r0, v4, r4;
    logic [95:0] d1, d0, d4;
    logic [7:0]  c1, c0, c4;
    logic [15:0] s1, s0;
    logic [3:0]  s4;

    int n_vec = 0;
    int n_err = 0;
    bit armed = 0;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_dut_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_ctrl(c1),
        .stall_cnt(s1)
    );

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_dut_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_ctrl(c0),
        .stall_cnt(s0)
    );

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r4), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(v4), .out_ready(out_ready), .out_data(d4), .out_ctrl(c4),
        .stall_cnt(s4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model: bounded FIFO per instance -------
    int          m_cnt[3];
    logic [95:0] m_d[3][2];
    logic [7:0]  m_c[3][2];
    logic [95:0] m_last[3];
    int          m_stall[3];
    int          m_max[3];
    bit          m_skid[3];
    bit          m_acc[3];

    function automatic bit mready(input int i);
        if (m_skid[i]) return (m_cnt[i] < 2);
        return (m_cnt[i] == 0) || out_ready;
    endfunction

    initial begin
        m_skid[0] = 1'b1; m_max[0] = 65535;
        m_skid[1] = 1'b0; m_max[1] = 65535;
        m_skid[2] = 1'b1; m_max[2] = 15;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_stall[i] = 0; m_last[i] = '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) m_acc[i] = in_valid && mready(i);
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    m_cnt[i]   = 0;
                    m_last[i]  = '0;
                    m_stall[i] = 0;
                end else begin
                    if (m_cnt[i] > 0 && !out_ready && m_stall[i] < m_max[i])
                        m_stall[i]++;
                    if (flush) begin
                        m_cnt[i] = 0;
                    end else begin
                        if (m_cnt[i] > 0 && out_ready) begin
                            m_d[i][0] = m_d[i][1];
                            m_c[i][0] = m_c[i][1];
                            m_cnt[i]--;
                        end
                        if (m_acc[i]) begin
                            m_d[i][m_cnt[i]] = in_data;
                            m_c[i][m_cnt[i]] = in_ctrl;
                            m_cnt[i]++;
                        end
                    end
                    if (m_cnt[i] > 0) m_last[i] = m_d[i][0];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int i, input logic v, input logic r,
                           input logic [95:0] d, input logic [7:0] c,
                           input logic [15:0] s);
        chk($sformatf("dut%0d out_valid", i), 128'(v), 128'(m_cnt[i] > 0));
        chk($sformatf("dut%0d in_ready", i),  128'(r), 128'(mready(i)));
        chk($sformatf("dut%0d out_data", i),  128'(d), 128'(m_last[i]));
        chk($sformatf("dut%0d out_ctrl", i),  128'(c),
            (m_cnt[i] > 0) ? 128'(m_c[i][0]) : 128'(0));
        chk($sformatf("dut%0d stall_cnt", i), 128'(s), 128'(m_stall[i]));
    endtask

    // Compare process: every falling edge once reset has been applied.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            cmp_dut(0, v1, r1, d1, c1, s1);
            cmp_dut(1, v0, r0, d0, c0, s0);
            cmp_dut(2, v4, r4, d4, c4, {12'b0, s4});
        end
    end

    // ---------------- directed stimulus ----------------------------------
    task automatic drive(input logic v, input logic [95:0] d, input logic [7:0] c,
                         input logic rdy, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = rdy;
        flush     = f;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 96'hDEAD, 8'hFF, 1'b0, 1'b0);
        step; step;
        chk("reset out_valid", 128'(v1), 128'(0));
        chk("reset out_ctrl",  128'(c1), 128'(0));
        chk("reset out_data",  128'(d1), 128'(0));
        chk("reset in_ready",  128'(r1), 128'(1));
        chk("reset stall_cnt", 128'(s1), 128'(0));
        armed = 1'b1;

        // Streaming 1..8 at full rate.
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 96'(k), 8'(8'h10 + k), 1'b1, 1'b0);
            step;
            chk("stream out_data", 128'(d1), 128'(k));
            chk("stream in_ready", 128'(r1), 128'(1));
            chk("stream nskid out_data", 128'(d0), 128'(k));
        end
        drive(1'b0, 96'h0, 8'h00, 1'b1, 1'b0);
        step;
        chk("stream end out_valid", 128'(v1), 128'(0));

        // Back-pressure: 3 in main, 4 in skid, 5 held off.
        drive(1'b1, 96'd3, 8'h03, 1'b0, 1'b0); step;
        drive(1'b1, 96'd4, 8'h04, 1'b0, 1'b0); step;
        chk("bp in_ready full", 128'(r1), 128'(0));
        drive(1'b1, 96'd5, 8'h05, 1'b0, 1'b0); step; step;
        chk("bp out_data held", 128'(d1), 128'(3));
        chk("bp in_ready held", 128'(r1), 128'(0));
        chk("bp stall_cnt",     128'(s1), 128'(3));
        drive(1'b1, 96'd5, 8'h05, 1'b1, 1'b0); step;
        chk("bp drain 4", 128'(d1), 128'(4));
        chk("bp ready back", 128'(r1), 128'(1));
        step;
        chk("bp drain 5", 128'(d1), 128'(5));
        drive(1'b0, 96'h0, 8'h00, 1'b1, 1'b0); step;
        chk("bp empty", 128'(v1), 128'(0));
        chk("bp stall final", 128'(s1), 128'(3));

        // Flush with two bundles held and a bundle offered.
        drive(1'b1, 96'h11, 8'h11, 1'b0, 1'b0); step;
        drive(1'b1, 96'h22, 8'h22, 1'b0, 1'b0); step;
        drive(1'b1, 96'h33, 8'h33, 1'b0, 1'b1); step;
        chk("flush out_valid", 128'(v1), 128'(0));
        chk("flush out_ctrl",  128'(c1), 128'(0));
        chk("flush in_ready",  128'(r1), 128'(1));
        drive(1'b1, 96'hA5, 8'hA5, 1'b1, 1'b0); step;
        chk("flush next data", 128'(d1), 128'(96'hA5));
        chk("flush next ctrl", 128'(c1), 128'(8'hA5));
        drive(1'b0, 96'h0, 8'h00, 1'b1, 1'b0); step;
        chk("flush alone", 128'(v1), 128'(0));

        // Bubble after a single bundle.
        drive(1'b1, 96'h77, 8'h3C, 1'b1, 1'b0); step;
        chk("bubble ctrl in", 128'(c1), 128'(8'h3C));
        drive(1'b0, 96'h0, 8'h00, 1'b1, 1'b0); step;
        chk("bubble out_valid", 128'(v1), 128'(0));
        chk("bubble out_ctrl",  128'(c1), 128'(0));
        chk("bubble data hold", 128'(d1), 128'(96'h77));

        // Saturation of the 4-bit counter.
        drive(1'b1, 96'h99, 8'h01, 1'b0, 1'b0); step;
        drive(1'b0, 96'h0, 8'h00, 1'b0, 1'b0);
        repeat (20) step;
        chk("sat cnt4", 128'(s4), 128'(15));
        chk("sat cnt16", 128'(s1), 128'(25));
        repeat (3) step;
        chk("sat cnt4 hold", 128'(s4), 128'(15));
        chk("sat cnt16 more", 128'(s1), 128'(28));

        // Mid-stream reset drops the held bundle and clears the counter.
        reset = 1'b0; step;
        chk("midreset out_valid", 128'(v1), 128'(0));
        chk("midreset stall_cnt", 128'(s1), 128'(0));
        chk("midreset in_ready",  128'(r1), 128'(1));
        reset = 1'b1;
        drive(1'b1, 96'h42, 8'h42, 1'b1, 1'b0); step;
        chk("after reset data", 128'(d1), 128'(96'h42));
        drive(1'b0, 96'h0, 8'h00, 1'b1, 1'b0); step; step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
